// File: rtl/ram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Shares one single-port synchronous RAM between instruction fetch
//            (port 0), CPU load/store (port 1) and debug/loader (port 2).
//            Round-robin arbitration (optional strict priority for port 2),
//            one outstanding RAM transaction at a time, CPU stall generation.
// Ports    : clk_cpu, reset (async, active-low)
//            req/we[2:0], adrs0..2, wdata0..2   - requester side
//            ack[2:0], err, rdata               - completion side
//            mem_en, mem_we, mem_adrs, mem_wdata, mem_q - RAM side
//            cpu_stall                          - CPU hold (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int RAM_LAT  = 1,
  parameter int ADDR_W   = 8,
  parameter int DBG_PRIO = 0
) (
  input  logic              clk_cpu,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [31:0]       adrs0,
  input  logic [31:0]       adrs1,
  input  logic [31:0]       adrs2,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  input  logic [31:0]       wdata2,
  output logic [2:0]        ack,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adrs,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_q,
  output logic              cpu_stall
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(RAM_LAT - 1);

  state_t              state_q;
  logic [1:0]          owner_q;
  logic                prio_win_q;
  logic                we_q;
  logic [1:0]          rr_q;
  logic [1:0]          cnt_q;
  logic [2:0]          ack_q;
  logic                err_q;
  logic [31:0]         rdata_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_adrs_q;
  logic [31:0]         mem_wdata_q;

  // Arbitration result and the winner's request fields
  logic [1:0]  grant_idx;
  logic        grant_prio;
  logic        sel_we;
  logic [31:0] sel_adrs;
  logic [31:0] sel_wdata;

  always_comb begin
    grant_idx  = 2'd0;
    grant_prio = 1'b0;
    if (DBG_PRIO != 0 && req[2]) begin
      grant_idx  = 2'd2;
      grant_prio = 1'b1;
    end else begin
      // First requesting port at or after the rotation pointer
      case (rr_q)
        2'd1:    grant_idx = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
        2'd2:    grant_idx = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
        default: grant_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      endcase
    end
  end

  always_comb begin
    case (grant_idx)
      2'd1: begin sel_we = we[1]; sel_adrs = adrs1; sel_wdata = wdata1; end
      2'd2: begin sel_we = we[2]; sel_adrs = adrs2; sel_wdata = wdata2; end
      default: begin sel_we = we[0]; sel_adrs = adrs0; sel_wdata = wdata0; end
    endcase
  end

  // Address bits above the RAM size wrap silently
  logic unused_adrs_hi;
  assign unused_adrs_hi = ^sel_adrs[31:ADDR_W+2];

  always_ff @(posedge clk_cpu or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 2'd0;
      prio_win_q  <= 1'b0;
      we_q        <= 1'b0;
      rr_q        <= 2'd0;
      cnt_q       <= 2'd0;
      ack_q       <= 3'b000;
      err_q       <= 1'b0;
      rdata_q     <= 32'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_adrs_q  <= '0;
      mem_wdata_q <= 32'd0;
    end else begin
      // ack and mem_en are single-cycle pulses
      ack_q    <= 3'b000;
      mem_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            owner_q    <= grant_idx;
            prio_win_q <= grant_prio;
            we_q       <= sel_we;
            if (sel_adrs[1:0] != 2'b00) begin
              // Misaligned: complete immediately with error, no RAM cycle
              state_q <= S_DONE;
              ack_q   <= 3'(1) << grant_idx;
              err_q   <= 1'b1;
              rdata_q <= 32'd0;
            end else begin
              state_q     <= S_ACCESS;
              mem_en_q    <= 1'b1;
              mem_we_q    <= sel_we;
              mem_adrs_q  <= sel_adrs[ADDR_W+1:2];
              mem_wdata_q <= sel_wdata;
            end
          end
        end
        S_ACCESS: begin
          state_q  <= S_WAIT;
          cnt_q    <= LAT_M1;
          mem_we_q <= 1'b0;
        end
        S_WAIT: begin
          if (cnt_q == 2'd0) begin
            state_q <= S_DONE;
            rdata_q <= we_q ? 32'd0 : mem_q;
            err_q   <= 1'b0;
            ack_q   <= 3'(1) << owner_q;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          // A priority win by port 2 leaves the rotation untouched
          if (!prio_win_q) begin
            rr_q <= (owner_q == 2'd2) ? 2'd0 : owner_q + 2'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_adrs  = mem_adrs_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_stall = (req[0] & ~ack_q[0]) | (req[1] & ~ack_q[1]);

endmodule
`default_nettype wire
